// File: rtl/adder_bist_checker.sv
// Built-in self-test sequencer and checker for the Brent-Kung adder.
// Sweeps every operand pair, waits a settle window, and compares the adder's
// sum against a reference. Counts mismatches and captures the first failure.
module adder_bist_checker #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH:0]   dut_sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH:0]   fail_sum
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   op_a, op_a_nxt;
    logic [WIDTH-1:0]   op_b, op_b_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [7:0]         err_nxt;
    logic [WIDTH-1:0]   fail_a_nxt, fail_b_nxt;
    logic [WIDTH:0]     fail_sum_nxt;
    logic               first_fail, first_fail_nxt;
    logic               busy_nxt, done_nxt, pass_nxt;

    logic [WIDTH:0]     ref_sum;
    logic               mismatch;
    logic               last_vec;
    logic [2*WIDTH-1:0] pair_inc;

    // Error counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign ref_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign mismatch = (dut_sum != ref_sum);
    assign last_vec = &{op_a, op_b};
    assign pair_inc = {op_a, op_b} + (2*WIDTH)'(1);

    assign dut_a = op_a;
    assign dut_b = op_b;

    // Next-state and next-output decode; every register holds unless changed here.
    always_comb begin
        state_nxt      = state;
        op_a_nxt       = op_a;
        op_b_nxt       = op_b;
        cnt_nxt        = cnt;
        err_nxt        = err_count;
        fail_a_nxt     = fail_a;
        fail_b_nxt     = fail_b;
        fail_sum_nxt   = fail_sum;
        first_fail_nxt = first_fail;
        busy_nxt       = busy;
        done_nxt       = done;
        pass_nxt       = pass;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt      = S_WAIT;
                    op_a_nxt       = '0;
                    op_b_nxt       = '0;
                    cnt_nxt        = CNT_INIT;
                    err_nxt        = '0;
                    fail_a_nxt     = '0;
                    fail_b_nxt     = '0;
                    fail_sum_nxt   = '0;
                    first_fail_nxt = 1'b0;
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    pass_nxt       = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_CHECK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_nxt = sat_inc(err_count);
                    if (!first_fail) begin
                        first_fail_nxt = 1'b1;
                        fail_a_nxt     = op_a;
                        fail_b_nxt     = op_b;
                        fail_sum_nxt   = dut_sum;
                    end
                end
                if (last_vec) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == 8'd0);
                end else begin
                    state_nxt = S_WAIT;
                    op_a_nxt  = pair_inc[2*WIDTH-1:WIDTH];
                    op_b_nxt  = pair_inc[WIDTH-1:0];
                    cnt_nxt   = CNT_INIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and result registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sum   <= '0;
            first_fail <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (ena) begin
            state      <= state_nxt;
            op_a       <= op_a_nxt;
            op_b       <= op_b_nxt;
            cnt        <= cnt_nxt;
            err_count  <= err_nxt;
            fail_a     <= fail_a_nxt;
            fail_b     <= fail_b_nxt;
            fail_sum   <= fail_sum_nxt;
            first_fail <= first_fail_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Directed bench for adder_bist_checker: behavioural adder models with planted
// faults, plus a second instance with a longer settle window driving a
// three-cycle-latency adder.
module tb_adder_bist_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dut_a, dut_b, fail_a, fail_b;
    logic [W:0]   dut_sum, fail_sum;
    logic         busy, done, pass;
    logic [7:0]   err_count;

    logic         ena3 = 1'b1;
    logic         start3 = 1'b0;
    logic [W-1:0] a3, b3, fa3, fb3;
    logic [W:0]   sum3, fs3;
    logic         busy3, done3, pass3;
    logic [7:0]   err3;
    logic [W:0]   d1 = '0, d2 = '0, d3 = '0;

    int mode = 0;
    int n_vec = 0;
    int n_miscmp = 0;
    int edges;

    always #5 clk = ~clk;

    // Adder model: 0 ideal, 1 sum bit 0 stuck at 0, 2 wrong only for 15+15, 3 always 0
    always_comb begin
        dut_sum = {1'b0, dut_a} + {1'b0, dut_b};
        case (mode)
            1: dut_sum[0] = 1'b0;
            2: if (dut_a == 4'd15 && dut_b == 4'd15) dut_sum = '0;
            3: dut_sum = '0;
            default: ;
        endcase
    end

    // Adder whose result appears three clocks after the operands change
    always @(posedge clk) begin
        d1 <= {1'b0, a3} + {1'b0, b3};
        d2 <= d1;
        d3 <= d2;
    end
    assign sum3 = d3;

    adder_bist_checker #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_sum(dut_sum),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum)
    );

    adder_bist_checker #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena3), .start(start3),
        .dut_a(a3), .dut_b(b3), .dut_sum(sum3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_a(fa3), .fail_b(fb3), .fail_sum(fs3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start pulse on dut, then count edges until done (bounded).
    task automatic sweep(input int budget, input int poke, input int freeze, output int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_err", 32'(err_count), 32'd0);
        chk("clr_fail", 32'({fail_a, fail_b, fail_sum}), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (n == poke) start = 1'b1;
            else if (n == poke + 1) start = 1'b0;
            if (n == freeze) begin
                ena = 1'b0;
                repeat (20) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("frz_a", 32'(dut_a), 32'd3);
                chk("frz_b", 32'(dut_b), 32'd2);
                chk("frz_busy", 32'(busy), 32'd1);
                ena = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_ops", 32'({dut_a, dut_b}), 32'd0);
        chk("rst_fail", 32'({fail_a, fail_b, fail_sum}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Ideal adder; a start pulse mid-sweep must be ignored
        mode = 0;
        sweep(600, 50, -100, edges);
        chk("ideal_edges", 32'(edges), 32'd512);
        chk("ideal_done", 32'(done), 32'd1);
        chk("ideal_pass", 32'(pass), 32'd1);
        chk("ideal_busy", 32'(busy), 32'd0);
        chk("ideal_err", 32'(err_count), 32'd0);
        chk("ideal_fail", 32'({fail_a, fail_b, fail_sum}), 32'd0);
        chk("ideal_ops", 32'({dut_a, dut_b}), 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_pass", 32'(pass), 32'd1);

        // Sum bit 0 stuck at 0
        mode = 1;
        sweep(600, -100, -100, edges);
        chk("s0_err", 32'(err_count), 32'd128);
        chk("s0_fail_a", 32'(fail_a), 32'd0);
        chk("s0_fail_b", 32'(fail_b), 32'd1);
        chk("s0_fail_sum", 32'(fail_sum), 32'd0);
        chk("s0_pass", 32'(pass), 32'd0);
        chk("s0_done", 32'(done), 32'd1);

        // Wrong only for 15+15
        mode = 2;
        sweep(600, -100, -100, edges);
        chk("ff_edges", 32'(edges), 32'd512);
        chk("ff_err", 32'(err_count), 32'd1);
        chk("ff_fail_a", 32'(fail_a), 32'd15);
        chk("ff_fail_b", 32'(fail_b), 32'd15);
        chk("ff_fail_sum", 32'(fail_sum), 32'd0);
        chk("ff_pass", 32'(pass), 32'd0);

        // Sum always 0: 255 mismatches, counter saturates
        mode = 3;
        sweep(600, -100, -100, edges);
        chk("z_err", 32'(err_count), 32'd255);
        chk("z_fail_a", 32'(fail_a), 32'd0);
        chk("z_fail_b", 32'(fail_b), 32'd1);
        chk("z_fail_sum", 32'(fail_sum), 32'd0);

        // ena low for 20 cycles after edge 100
        mode = 0;
        sweep(700, -100, 100, edges);
        chk("frz_edges", 32'(edges), 32'd532);
        chk("frz_pass", 32'(pass), 32'd1);
        chk("frz_err", 32'(err_count), 32'd0);

        // Asynchronous reset mid-sweep
        mode = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_err", 32'(err_count), 32'd49);
        chk("pre_rst_a", 32'(dut_a), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ops", 32'({dut_a, dut_b}), 32'd0);
        chk("arst_err", 32'(err_count), 32'd0);
        chk("arst_fail", 32'({fail_a, fail_b, fail_sum}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        // SETTLE_CYCLES=3 with a three-cycle-latency adder
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        edges = 0;
        while (!done3 && edges < 1200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("s3_edges", 32'(edges), 32'd1024);
        chk("s3_pass", 32'(pass3), 32'd1);
        chk("s3_err", 32'(err3), 32'd0);
        chk("s3_fail", 32'({fa3, fb3, fs3}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
